// File: rtl/inst_decode_stage.sv
// rtl/inst_decode_stage.sv - pipelined RV32 decode stage with a 2-entry skid buffer
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   flush               drops every buffered entry (reset has priority)
//   in_valid/in_ready   fetch side handshake; in_ready is registered
//   in_inst, in_pc      instruction word and its PC
//   out_valid/out_ready execute side handshake
//   out_pc .. out_funct7 raw RV32 fields of the held entry
//   out_fmt             R=0 I=1 S=2 B=3 U=4 J=5 illegal=7
//   out_imm, out_illegal sign-extended immediate, illegal-encoding flag
//   decoded_count       saturating count of output handshakes
module inst_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [6:0]       out_funct7,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decoded_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     fields;   // raw instruction bits, sliced on the way out
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  entry_t             dec;
  entry_t             out_q;
  entry_t             skid_q;
  logic               skid_valid;
  logic               skid_valid_n;
  logic               accept;
  logic signed [31:0] imm32;

  // Every recognised opcode ends in 2'b11, so a non-11 low pair falls to default.
  always_comb begin
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b1;
    imm32       = '0;
    case (in_inst[6:0])
      7'b0110011: begin
        dec.fmt = FMT_R; dec.illegal = 1'b0;
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec.fmt = FMT_I; dec.illegal = 1'b0;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FMT_S; dec.illegal = 1'b0;
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B; dec.illegal = 1'b0;
        imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U; dec.illegal = 1'b0;
        imm32   = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J; dec.illegal = 1'b0;
        imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      default: ;
    endcase
    dec.pc     = in_pc;
    dec.fields = in_inst;
    // Sized cast of a signed value sign-extends to XLEN.
    dec.imm    = XLEN'(imm32);
  end

  assign accept = in_valid && in_ready;

  // The skid slot only fills while the output slot is held by a stalled consumer.
  always_comb begin
    skid_valid_n = skid_valid;
    if (!out_valid || out_ready)
      skid_valid_n = 1'b0;
    else if (accept)
      skid_valid_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q         <= '0;
      skid_q        <= '0;
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      in_ready      <= 1'b1;
      decoded_count <= '0;
    end else begin
      if (out_valid && out_ready && decoded_count != CNT_MAX)
        decoded_count <= decoded_count + 1'b1;
      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else begin
        if (!out_valid || out_ready) begin
          if (skid_valid) begin
            out_q <= skid_q;
          end else if (accept) begin
            out_q     <= dec;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (accept) begin
          skid_q <= dec;
        end
        skid_valid <= skid_valid_n;
        in_ready   <= !skid_valid_n;
      end
    end
  end

  assign out_pc      = out_q.pc;
  assign out_opcode  = out_q.fields[6:0];
  assign out_rd      = out_q.fields[11:7];
  assign out_funct3  = out_q.fields[14:12];
  assign out_rs1     = out_q.fields[19:15];
  assign out_rs2     = out_q.fields[24:20];
  assign out_funct7  = out_q.fields[31:25];
  assign out_fmt     = out_q.fmt;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// tb/tb_inst_decode_stage.sv - bench for inst_decode_stage
module tb_inst_decode_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, flush, in_valid, out_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            in_ready, out_valid, out_illegal;
  logic [XLEN-1:0] out_pc, out_imm;
  logic [6:0]      out_opcode, out_funct7;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3, out_fmt;
  logic [15:0]     decoded_count;

  logic            flush2, in_valid2, out_ready2;
  logic [31:0]     in_inst2;
  logic [XLEN-1:0] in_pc2;
  logic            in_ready2, out_valid2, out_illegal2;
  logic [XLEN-1:0] out_pc2, out_imm2;
  logic [6:0]      out_opcode2, out_funct72;
  logic [4:0]      out_rd2, out_rs12, out_rs22;
  logic [2:0]      out_funct32, out_fmt2;
  logic [1:0]      decoded_count2;

  inst_decode_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
    .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal),
    .decoded_count(decoded_count)
  );

  inst_decode_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_inst(in_inst2), .in_pc(in_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_pc(out_pc2),
    .out_opcode(out_opcode2), .out_rd(out_rd2), .out_funct3(out_funct32),
    .out_rs1(out_rs12), .out_rs2(out_rs22), .out_funct7(out_funct72),
    .out_fmt(out_fmt2), .out_imm(out_imm2), .out_illegal(out_illegal2),
    .decoded_count(decoded_count2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        q[$];
  int unsigned mcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
    longint x;
    x = longint'({32'd0, w});
    return (x >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  function automatic longint sx(input longint v, input int n);
    if (v >= (longint'(1) << (n - 1))) return v - (longint'(1) << n);
    return v;
  endfunction

  // Reference decode: immediates rebuilt arithmetically from weighted bit fields.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t   e;
    longint op, v;
    op    = fld(w, 6, 0);
    e.pc  = pc;
    e.inst = w;
    e.ill = 1'b0;
    v     = 0;
    if (op == 'h33) e.fmt = 3'd0;
    else if (op == 'h13 || op == 'h03 || op == 'h67 || op == 'h73 || op == 'h0F) begin
      e.fmt = 3'd1; v = sx(fld(w, 31, 20), 12);
    end else if (op == 'h23) begin
      e.fmt = 3'd2; v = sx(fld(w, 31, 25) * 32 + fld(w, 11, 7), 12);
    end else if (op == 'h63) begin
      e.fmt = 3'd3;
      v = sx(fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2, 13);
    end else if (op == 'h37 || op == 'h17) begin
      e.fmt = 3'd4; v = sx(fld(w, 31, 12) * 4096, 32);
    end else if (op == 'h6F) begin
      e.fmt = 3'd5;
      v = sx(fld(w, 31, 31) * (longint'(1) << 20) + fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2, 21);
    end else begin
      e.fmt = 3'd7; e.ill = 1'b1;
    end
    e.imm = v[31:0];
    return e;
  endfunction

  task automatic check_state();
    logic [31:0] flds;
    flds = {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode};
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("decoded_count", decoded_count, mcnt);
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("fields", flds, q[0].inst);
      chk("out_fmt", out_fmt, q[0].fmt);
      chk("out_imm", out_imm, q[0].imm);
      chk("out_illegal", out_illegal, q[0].ill);
    end
  endtask

  // Advance the model with the inputs currently applied, clock once, compare.
  task automatic cycle();
    bit hs, acc;
    hs  = out_ready && (q.size() > 0);
    acc = in_valid && (q.size() < 2);
    if (reset) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (hs && mcnt < 65535) mcnt++;
      if (flush) q.delete();
      else begin
        if (hs) void'(q.pop_front());
        if (acc) q.push_back(ref_decode(in_inst, in_pc));
      end
    end
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_count"}, decoded_count, 16'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_imm"}, out_imm, 32'd0);
    chk({tag, "_fields"}, {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}, 32'd0);
    chk({tag, "_fmt_ill"}, {out_fmt, out_illegal}, 4'd0);
  endtask

  vec_t        tbl[10];
  logic [6:0]  ops[9];
  int unsigned cnt_before;
  logic [31:0] r;

  initial begin
    tbl[0] = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0, 5'd1, 5'd0};
    tbl[1] = '{32'h0020A423, 3'd2, 32'h00000008, 1'b0, 5'd8, 5'd1};
    tbl[2] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 5'd29, 5'd0};
    tbl[3] = '{32'h123452B7, 3'd4, 32'h12345000, 1'b0, 5'd5, 5'd8};
    tbl[4] = '{32'h001000EF, 3'd5, 32'h00000800, 1'b0, 5'd1, 5'd0};
    tbl[5] = '{32'h002081B3, 3'd0, 32'h00000000, 1'b0, 5'd3, 5'd1};
    tbl[6] = '{32'h0080A183, 3'd1, 32'h00000008, 1'b0, 5'd3, 5'd1};
    tbl[7] = '{32'h00000000, 3'd7, 32'h00000000, 1'b1, 5'd0, 5'd0};
    tbl[8] = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1, 5'd31, 5'd31};
    tbl[9] = '{32'h00000012, 3'd7, 32'h00000000, 1'b1, 5'd0, 5'd0};
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h6F};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0;
    flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; in_inst2 = 32'h00000013; in_pc2 = '0;
    cycle();
    cycle();
    check_reset_state("reset");
    reset = 1'b0;

    // Back-to-back table stream with out_ready high: each vector shows one cycle later.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_inst = tbl[i].inst; in_pc = 32'h100 + 32'(4 * i);
      cycle();
      chk("tbl_valid", out_valid, 1'b1);
      chk("tbl_pc", out_pc, 32'h100 + 32'(4 * i));
      chk("tbl_fmt", out_fmt, tbl[i].fmt);
      chk("tbl_imm", out_imm, tbl[i].imm);
      chk("tbl_ill", out_illegal, tbl[i].ill);
      chk("tbl_rd_rs1", {out_rd, out_rs1}, {tbl[i].rd, tbl[i].rs1});
    end
    in_valid = 1'b0;
    cycle();

    // Backpressure: three held instructions, two fit, third waits for space.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h200; cycle();
    in_inst = 32'h00200113; in_pc = 32'h204; cycle();
    chk("bp_in_ready_full", in_ready, 1'b0);
    in_inst = 32'h00300193; in_pc = 32'h208; cycle();
    chk("bp_hold_pc", out_pc, 32'h200);
    out_ready = 1'b1; cycle();
    chk("bp_second_pc", out_pc, 32'h204);
    chk("bp_in_ready_back", in_ready, 1'b1);
    cycle();
    chk("bp_third_pc", out_pc, 32'h208);
    in_valid = 1'b0; cycle();

    // Flush with both slots full and an input offered.
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00400213; in_pc = 32'h300; cycle();
    in_inst = 32'h00500293; in_pc = 32'h304; cycle();
    cnt_before = mcnt;
    flush = 1'b1; in_inst = 32'h00600313; in_pc = 32'h308; cycle();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_count", decoded_count, cnt_before);
    // Flush with empty buffer while an input is accepted: it must vanish.
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cycle();
    chk("flush_discard", out_valid, 1'b0);

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00700393; in_pc = 32'h400; cycle();
    in_inst = 32'h00800413; in_pc = 32'h404; cycle();
    reset = 1'b1; flush = 1'b1; cycle();
    check_reset_state("midreset");
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // Randomised traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      r = $urandom();
      if ($urandom_range(0, 3) != 0) in_inst = {r[31:7], ops[$urandom_range(0, 8)]};
      else in_inst = r;
      in_pc = $urandom();
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // Saturation on the 2-bit counter instance.
    in_valid2 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 3) chk("sat_count_2", decoded_count2, 2'd2);
      if (k == 4) chk("sat_count_3", decoded_count2, 2'd3);
    end
    chk("sat_count_hold", decoded_count2, 2'd3);
    in_valid2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- Pipelined, parametrised successor to the combinational RV32 field splitter.
- Accepts 32-bit instruction words with their PC over a valid/ready handshake and splits out opcode, rd, funct3, rs1, rs2 and funct7.
- Also classifies the format, generates the sign-extended immediate and flags illegal encodings.
- Registers the result into a 2-entry skid buffer so fetch and execute are decoupled at full throughput; sits between fetch and register-file read.

Parameters:
- XLEN, 32, datapath width of pc and imm; legal values 32 or 64.
- CNT_W, 16, width of the saturating decoded-instruction counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  instruction word valid.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- in_inst  input  32  instruction word.
- in_pc  input  XLEN  PC of in_inst.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  consumer accepts.
- out_pc  output  XLEN  PC of the entry.
- out_opcode  output  7  inst[6:0].
- out_rd  output  5  inst[11:7].
- out_funct3  output  3  inst[14:12].
- out_rs1  output  5  inst[19:15].
- out_rs2  output  5  inst[24:20].
- out_funct7  output  7  inst[31:25].
- out_fmt  output  3  format: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
- out_imm  output  XLEN  sign-extended immediate.
- out_illegal  output  1  illegal encoding.
- decoded_count  output  CNT_W  output handshakes since reset; saturating.

Behaviour:
- Reset: out_valid=0, skid_valid=0, in_ready=1, decoded_count=0. All payload registers are cleared to 0.
- Decode is combinational on in_inst; only the decoded result is stored (in out reg or skid reg).
- Format by opcode:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode, or inst[1:0]≠2'b11 → fmt=7, illegal=1, imm=0.
- Immediates, sign-extended from inst[31] to XLEN:
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'b0}.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R → imm=0.
- Field outputs (rd, rs1, …) are always the raw bit slices, including for illegal instructions.
- Accept: accept = in_valid && in_ready. accept and skid_valid are mutually exclusive by construction.
- Output register update occurs when !out_valid || out_ready:
  - if skid_valid: out ← skid, skid_valid ← 0;
  - else if accept: out ← new decode, out_valid ← 1;
  - else out_valid ← 0.
- Stall case: out_valid && !out_ready && accept → skid ← new decode, skid_valid ← 1.
- in_ready is a registered copy of !skid_valid (updated each cycle from next skid_valid).
- Latency: accept in cycle N → out_valid in N+1 when the buffer is empty. Throughput is 1/cycle with out_ready=1.
- Order is strictly preserved; no entry is dropped or duplicated.
- Payload is stable while out_valid && !out_ready.
- flush (when reset=0): next out_valid=0, skid_valid=0, in_ready=1. An input accepted in the flush cycle is discarded. decoded_count is unaffected by flush.
- decoded_count increments on out_valid && out_ready and saturates at 2^CNT_W−1.
- Reset has priority over flush. Reset mid-stall empties the buffer the same way as flush and also clears decoded_count.
- XLEN=64: field layouts are unchanged (RV32 encodings); only pc and imm widen.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), pc=0x100, out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, fmt=1, imm=0xFFFFFFFF, out_pc=0x100, illegal=0.
- Back-to-back stream: sw x2,8(x1) (0x0020A423) → fmt=2, imm=8, rs1=1, rs2=2; then beq x0,x0,-4 (0xFE000EE3) → fmt=3, imm=0xFFFFFFFC; then lui x5,0x12345 (0x123452B7) → fmt=4, imm=0x12345000; then jal x1,2048 (0x001000EF) → fmt=5, imm=0x800. Outputs appear on consecutive cycles in order.
- Backpressure: out_ready=0, in_valid held with 3 instructions → 2 accepted, in_ready=0 the cycle after the 2nd. Raise out_ready → outputs appear in order, in_ready returns to 1, 3rd is accepted; no loss.
- Illegal inputs: 0x00000000 and 0xFFFFFFFF → fmt=7, illegal=1, imm=0, fields still equal the raw bit slices.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1, the input is discarded, decoded_count unchanged. Reset asserted mid-stream → all outputs zero and decoded_count=0 the next cycle.
- Saturation with CNT_W=2: 5 output handshakes → decoded_count stays 3.
